// File: rtl/uart_rx.sv
// UART receiver: oversamples rx_in at `prescale` clocks per bit, majority-votes
// three mid-bit samples, checks start/parity/stop and emits one-cycle result pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   pre_r;
  logic                    pen;
  logic                    ptyp;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [2:0]              samp;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    perr;

  logic [PRESCALE_W-1:0]   half;
  logic                    last;
  logic                    bitv;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic par_mismatch(input logic [DATA_WIDTH-1:0] d,
                                        input logic odd, input logic rxbit);
    return rxbit != ((^d) ^ odd);
  endfunction

  assign half = pre_r >> 1;
  assign last = (edge_cnt == pre_r - ONE);
  assign bitv = maj3(samp);

  // Mid-bit samples are not reset: each is rewritten before any decision reads it.
  always_ff @(posedge clk) begin
    if (state != IDLE) begin
      if (edge_cnt == half - ONE) samp[0] <= rx_in;
      if (edge_cnt == half)       samp[1] <= rx_in;
      if (edge_cnt == half + ONE) samp[2] <= rx_in;
    end
    if (state == DATA && last) shreg <= {bitv, shreg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pre_r      <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      perr       <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != IDLE) edge_cnt <= last ? '0 : edge_cnt + ONE;
      case (state)
        IDLE: begin
          // The detection cycle is edge 0 of the start bit; frame settings freeze here.
          if (!rx_in) begin
            state    <= START;
            edge_cnt <= ONE;
            bit_cnt  <= '0;
            pre_r    <= prescale;
            pen      <= par_en;
            ptyp     <= par_typ;
            perr     <= 1'b0;
          end
        end
        START: if (last) state <= bitv ? IDLE : DATA;
        DATA: begin
          if (last) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) state <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (last) begin
            perr  <= par_mismatch(shreg, ptyp, bitv);
            state <= STOP;
          end
        end
        STOP: begin
          if (last) begin
            state   <= IDLE;
            par_err <= perr;
            stp_err <= ~bitv;
            if (!perr && bitv) begin
              p_data     <= shreg;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit and result pulses are
// checked against hand-computed cycle positions and values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int failures = 0;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive rx_in for this cycle, then look just after the edge.
  task automatic step(input logic b);
    rx_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    int sp = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      if (data_valid || par_err || stp_err) sp++;
    end
    chk({tag, "_idle_quiet"}, sp, 0);
  endtask

  // Sends one frame; pulses are expected only right after the last stop-bit edge.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic pbit,
                            input logic sbit, input logic [5:0] p, input logic pe,
                            input logic pt, input logic edv, input logic epe,
                            input logic ese, input logic [7:0] epd);
    logic bits [0:10];
    int   nb;
    int   sp = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = pe ? pbit : sbit;
    bits[10] = sbit;
    nb = pe ? 11 : 10;
    prescale = p;
    par_en   = pe;
    par_typ  = pt;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < int'(p); e++) begin
        step(bits[b]);
        if (b == 0 && e == 0) begin
          // Mid-frame setting changes must not disturb this frame.
          prescale = (p == 6'd8) ? 6'd16 : 6'd8;
          par_en   = ~pe;
          par_typ  = ~pt;
        end
        if (!(b == nb - 1 && e == int'(p) - 1) && (data_valid || par_err || stp_err)) sp++;
      end
    end
    chk({tag, "_no_early_pulse"}, sp, 0);
    chk({tag, "_data_valid"}, data_valid, edv);
    chk({tag, "_par_err"}, par_err, epe);
    chk({tag, "_stp_err"}, stp_err, ese);
    chk({tag, "_p_data"}, p_data, epd);
  endtask

  initial begin
    int sp;
    // Reset state
    step(1'b1); step(1'b1); step(1'b1);
    chk("rst_p_data", p_data, 8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_stp_err", stp_err, 1'b0);
    rst = 1'b1;
    idle("post_rst", 4);

    // Plain frame, prescale 8: pulse in cycle 80
    send_frame("a5", 8'hA5, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    step(1'b1);
    chk("a5_pulse_one_cycle", data_valid, 1'b0);
    idle("a5", 3);

    // Even parity, 0x3C has even ones so parity bit 1 is wrong
    send_frame("par", 8'h3C, 1'b1, 1'b1, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    step(1'b1);
    chk("par_pulse_one_cycle", par_err, 1'b0);
    idle("par", 3);

    // Two-cycle glitch rejected; next frame starts right at cycle 8
    prescale = 6'd8;
    par_en = 1'b0;
    sp = 0;
    for (int i = 0; i < 8; i++) begin
      step(i < 2 ? 1'b0 : 1'b1);
      if (data_valid || par_err || stp_err) sp++;
    end
    chk("glitch_quiet", sp, 0);
    send_frame("5a", 8'h5A, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    idle("5a", 3);

    // Stop bit 0 at prescale 16
    send_frame("stp", 8'h81, 1'b0, 1'b0, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    idle("stp", 20);

    // Back-to-back odd-parity frames, prescale 16 then 32
    send_frame("b16_0", 8'h00, 1'b1, 1'b1, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame("b16_1", 8'hFF, 1'b1, 1'b1, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    idle("b16", 4);
    send_frame("b32_0", 8'h00, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame("b32_1", 8'hFF, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    idle("b32", 4);

    // Reset during the data bits of a frame abandons it
    prescale = 6'd8;
    par_en = 1'b0;
    step(1'b0);
    for (int i = 1; i < 8; i++) step(1'b0);
    for (int i = 0; i < 20; i++) step(i[0]);
    rst = 1'b0;
    step(1'b1);
    chk("midrst_p_data", p_data, 8'h00);
    chk("midrst_data_valid", data_valid, 1'b0);
    chk("midrst_par_err", par_err, 1'b0);
    chk("midrst_stp_err", stp_err, 1'b0);
    rst = 1'b1;
    idle("midrst", 100);
    send_frame("c3", 8'hC3, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    idle("c3", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the system UART, the stage directly downstream of the transmit path's serial line. Oversamples the asynchronous `rx_in` line at `prescale` clocks per bit, majority-votes three mid-bit samples, and checks start, optional parity and stop bits. A good frame yields an 8-bit byte with a one-cycle `data_valid` pulse toward the data synchronizer and system controller; bad frames yield one-cycle error pulses.

## Interface
- DATA_WIDTH, 8, payload bits per frame (LSB first)
- PRESCALE_W, 6, width of `prescale`
- clk  input  1  single clock for all logic
- rst  input  1  synchronous, active-low reset
- rx_in  input  1  serial line; idle high; already synchronized to clk
- prescale  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32; other values undefined
- par_en  input  1  1 = parity bit present after data
- par_typ  input  1  0 = even, 1 = odd
- p_data  output  DATA_WIDTH  last good byte, held until the next good frame
- data_valid  output  1  one-cycle pulse, `p_data` new this cycle
- par_err  output  1  one-cycle pulse, parity mismatch
- stp_err  output  1  one-cycle pulse, stop bit sampled 0

## Operation
- Reset (`rst`=0 at a clk edge): FSM to IDLE, counters 0; `p_data`=0, `data_valid`=`par_err`=`stp_err`=0 from that edge. Reset mid-frame abandons the frame with no pulse.
- `prescale`, `par_en` and `par_typ` are registered in the start-detection cycle and held for the whole frame. Changes mid-frame do not affect it.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `edge_cnt` runs 0..prescale-1 within a bit and wraps.
  - `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- IDLE:
  - `rx_in`=0 seen at an edge makes that cycle edge 0 of the start bit. Go to START.
  - Otherwise stay in IDLE.
- Sampling:
  - Each bit is sampled at edges prescale/2-1, prescale/2 and prescale/2+1.
  - Bit value = majority of the three samples.
- Bit decisions are taken at edge prescale-1 of each bit:
  - START: majority 1 (glitch) → IDLE, no output. Otherwise → DATA.
  - DATA: shift the bit into the deserializer LSB-first. After bit DATA_WIDTH-1, go to PARITY if `par_en`, else STOP.
  - PARITY: expected bit = XOR(data) ^ `par_typ`. Record mismatch → STOP.
  - STOP: evaluate the frame → IDLE.
- Frame result, registered on the edge closing the stop bit:
  - Parity mismatch → `par_err`=1.
  - Stop bit 0 → `stp_err`=1.
  - Both can be 1 together.
  - Neither → `p_data` ← deserializer and `data_valid`=1.
  - On error, `data_valid` stays 0 and `p_data` is unchanged.
- After a stop error the FSM still returns to IDLE. If the line is held low (break), the next cycle is treated as a new start detection.
- At most one of {`data_valid`, error pulse} per frame. All outputs are registered.

## Timing
- Cycle 0 is the start-detection cycle. F = 10 (no parity) or 11 (parity).
- Bit k occupies cycles k·prescale .. k·prescale+prescale-1.
- The stop bit ends at cycle F·prescale-1.
- `data_valid` or the error pulse is high during cycle F·prescale only.
- The FSM is in IDLE during cycle F·prescale. `rx_in`=0 in that cycle starts the next frame, so back-to-back frames are received with zero gap.
- A glitch is rejected at cycle prescale-1, with IDLE in cycle prescale.

## Test plan
- prescale=8, par_en=0, send 0xA5 with stop=1 → `data_valid` high only in cycle 80, `p_data`=0xA5, no errors.
- prescale=8, par_en=1, par_typ=0, send 0x3C with parity bit 1 → `par_err` pulse in cycle 88, no `data_valid`, `p_data` keeps its previous value.
- prescale=8, `rx_in` low for 2 cycles, then high → no outputs, FSM back in IDLE by cycle 8. A valid 0x5A sent afterwards is received correctly.
- prescale=16, par_en=0, send 0x81 with stop bit 0 → `stp_err` pulse in cycle 160, no `data_valid`.
- prescale=16, par_en=1, par_typ=1, back-to-back 0x00 (parity 1) then 0xFF (parity 1) with zero idle → `data_valid` in cycles 176 and 352 with `p_data`=0x00, then 0xFF. Repeat with prescale=32 → cycles 352 and 704.
- Assert `rst`=0 for one cycle during DATA of a frame → all outputs 0 next cycle and no pulse for that frame. The following clean frame 0xC3 is received normally.
